mem_host_initiator: RTL

- Host-side initiator for the memory controller's request interface.
- Accepts one command at a time on a valid/ready command port and converts it into a single-cycle wr_en/rd_en strobe with addr/wr_data held stable.
- Waits for the controller's ready pulse, then returns read data or write completion on a valid/ready response port.
- Sits between the processing logic and the memory controller. One outstanding transaction at a time.

---
 rtl/mem_host_initiator_pkg.sv | 14 +
 rtl/mem_host_initiator_if.sv | 41 ++++
 rtl/mem_host_initiator_sat_counter.sv | 20 ++
 rtl/mem_host_initiator.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mem_host_initiator_pkg.sv
// Shared types and default widths for the host-side memory initiator.
package mem_if_pkg;

   localparam int unsigned MEM_ADDR_W = 8;
   localparam int unsigned MEM_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } memi_state_t;

endpackage

// File: rtl/mem_host_initiator_if.sv
// Command, response and controller-side signals of the memory initiator.
// master: the initiator itself; slave: the processing logic plus controller.
interface mem_host_initiator_if import mem_if_pkg::*; #(
   parameter int unsigned ADDR_WIDTH = MEM_ADDR_W,
   parameter int unsigned DATA_WIDTH = MEM_DATA_W
) ();

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_write;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   logic                  ctl_wr_en;
   logic                  ctl_rd_en;
   logic [ADDR_WIDTH-1:0] ctl_addr;
   logic [DATA_WIDTH-1:0] ctl_wr_data;
   logic [DATA_WIDTH-1:0] ctl_rd_data;
   logic                  ctl_ready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  rsp_ready, ctl_rd_data, ctl_ready,
      output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
      output ctl_wr_en, ctl_rd_en, ctl_addr, ctl_wr_data
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output rsp_ready, ctl_rd_data, ctl_ready,
      input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
      input  ctl_wr_en, ctl_rd_en, ctl_addr, ctl_wr_data
   );

endinterface

// File: rtl/mem_host_initiator_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module memi_sat_counter import mem_if_pkg::*; #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Count one event per inc cycle until all-ones is reached.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/mem_host_initiator.sv
// Host-side initiator: one outstanding command, turned into a single-cycle
// controller strobe, completed on a valid/ready response port.
// Optional build macro MEMI_TIMEOUT_EN adds a WAIT-state timeout that
// returns rsp_err=1 after TIMEOUT_CYCLES cycles without ctl_ready.
module mem_host_initiator import mem_if_pkg::*; #(
   parameter int unsigned ADDR_WIDTH     = MEM_ADDR_W,
   parameter int unsigned DATA_WIDTH     = MEM_DATA_W,
   parameter int unsigned CNT_WIDTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mem_host_initiator_if.master bus,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] wr_done_cnt,
   output logic [CNT_WIDTH-1:0] rd_done_cnt
);

   // A zero limit would time out before WAIT is ever entered.
   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("mem_host_initiator: TIMEOUT_CYCLES must be at least 1");
   end

   memi_state_t state;
   logic        lat_write;
   logic        rsp_fire_c;
   logic        wr_inc_c;
   logic        rd_inc_c;

`ifdef MEMI_TIMEOUT_EN
   localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WAIT_W-1:0] wait_cnt;
`endif

   // Timed-out transactions complete on the port but are not counted.
   assign rsp_fire_c = (state == RESP) && bus.rsp_ready;
   assign wr_inc_c   = rsp_fire_c && lat_write && !bus.rsp_err;
   assign rd_inc_c   = rsp_fire_c && !lat_write && !bus.rsp_err;

   // Transaction sequencer with all handshake and controller outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         lat_write       <= 1'b0;
         busy            <= 1'b0;
         bus.cmd_ready   <= 1'b1;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_write   <= 1'b0;
         bus.rsp_rdata   <= '0;
         bus.rsp_err     <= 1'b0;
         bus.ctl_wr_en   <= 1'b0;
         bus.ctl_rd_en   <= 1'b0;
         bus.ctl_addr    <= '0;
         bus.ctl_wr_data <= '0;
`ifdef MEMI_TIMEOUT_EN
         wait_cnt        <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid && bus.cmd_ready) begin
                  state           <= ISSUE;
                  lat_write       <= bus.cmd_write;
                  busy            <= 1'b1;
                  bus.cmd_ready   <= 1'b0;
                  bus.ctl_addr    <= ADDR_WIDTH'(bus.cmd_addr);
                  bus.ctl_wr_data <= DATA_WIDTH'(bus.cmd_wdata);
                  bus.ctl_wr_en   <= bus.cmd_write;
                  bus.ctl_rd_en   <= !bus.cmd_write;
               end
            end
            ISSUE: begin
               // Strobe is a one-cycle pulse so the controller fires only once.
               state         <= WAIT;
               bus.ctl_wr_en <= 1'b0;
               bus.ctl_rd_en <= 1'b0;
`ifdef MEMI_TIMEOUT_EN
               wait_cnt      <= '0;
`endif
            end
            WAIT: begin
               // ctl_ready takes priority over a timeout in the same cycle.
               if (bus.ctl_ready) begin
                  state         <= RESP;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_write <= lat_write;
                  bus.rsp_rdata <= lat_write ? '0 : bus.ctl_rd_data;
                  bus.rsp_err   <= 1'b0;
               end
`ifdef MEMI_TIMEOUT_EN
               else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                  state         <= RESP;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_write <= lat_write;
                  bus.rsp_rdata <= '0;
                  bus.rsp_err   <= 1'b1;
               end else begin
                  wait_cnt      <= wait_cnt + WAIT_W'(1);
               end
`endif
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state         <= IDLE;
                  busy          <= 1'b0;
                  bus.rsp_valid <= 1'b0;
                  bus.cmd_ready <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   memi_sat_counter #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (wr_inc_c),
      .count (wr_done_cnt)
   );

   memi_sat_counter #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (rd_inc_c),
      .count (rd_done_cnt)
   );

endmodule
